// File: rtl/program_loader.sv
// Boot loader: streams an image (length byte, data bytes) into ROM/RAM and holds the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              R,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              core_R,
  output logic              done,
  output logic              err,
  output logic [8:0]        byte_cnt
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready;
  // in_data is don't-care otherwise and the source must hold it until taken.
  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    CHK  = 3'd2,
`endif
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [7:0] MAX_L = 8'(MAX_WORDS);

  state_t     state_q, state_d;
  logic [8:0] total_q;
  logic [8:0] cnt_inc;
  logic       accept;
  logic       len_ok;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
`endif

  assign accept  = in_valid && in_ready;
  assign cnt_inc = byte_cnt + 9'd1;
  assign len_ok  = (in_data != 8'd0) && (in_data <= MAX_L);
  assign done    = (state_q == RUN);
  assign err     = (state_q == ERR);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      LEN: begin
        in_ready = 1'b1;
        if (accept) state_d = len_ok ? DATA : ERR;
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && (cnt_inc == total_q)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (accept) state_d = (in_data == xor_q) ? RUN : ERR;
      end
`endif
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= LEN;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= 8'd0;
      core_R   <= 1'b1;
      byte_cnt <= 9'd0;
      total_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      // Lags the state by one edge so the final write lands before release.
      core_R  <= (state_q != RUN);
      mem_we  <= 1'b0;
      if (accept && state_q == LEN) total_q <= {in_data[6:0], 2'b00};
      if (accept && state_q == DATA) begin
        mem_we   <= 1'b1;
        mem_addr <= byte_cnt[ADDR_W-1:0];
        mem_data <= in_data;
        byte_cnt <= cnt_inc;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (R || state_q == LEN) xor_q <= 8'd0;
    else if (accept && state_q == DATA) xor_q <= xor_q ^ in_data;
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected {addr,data} writes plus status checks.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, mem_we, core_R, done, err;
  logic [7:0] mem_addr, mem_data;
  logic [8:0] byte_cnt;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [8:0]  addr_m = 9'd0;
  logic [7:0]  xor_m = 8'd0;

  program_loader dut (
    .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .core_R(core_R),
    .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("write_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("write_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic do_reset();
    // Hold R with a byte offered; the byte must be dropped.
    R = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    repeat (2) @(posedge clk);
    #1;
    R = 1'b0; in_valid = 1'b0;
    check("queue_empty_at_reset", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    addr_m = 9'd0; xor_m = 8'd0;
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_mem_we", 16'(mem_we), 16'd0);
    check("rst_mem_addr", 16'(mem_addr), 16'd0);
    check("rst_mem_data", 16'(mem_data), 16'd0);
    check("rst_core_R", 16'(core_R), 16'd1);
    check("rst_done", 16'(done), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_byte_cnt", 16'(byte_cnt), 16'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1; in_data = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back({addr_m[7:0], b});
    addr_m = addr_m + 9'd1;
    xor_m = xor_m ^ b;
    send_byte(b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that accepted the final byte of an image
  task automatic check_release(input string tag, input logic [8:0] cnt);
    check({tag, "_done_at_k"}, 16'(done), 16'd1);
    check({tag, "_coreR_at_k"}, 16'(core_R), 16'd1);
    check({tag, "_in_ready_run"}, 16'(in_ready), 16'd0);
`ifndef LOADER_CHECKSUM_EN
    check({tag, "_last_we"}, 16'(mem_we), 16'd1);
`endif
    @(posedge clk); #1;
    check({tag, "_coreR_at_k1"}, 16'(core_R), 16'd0);
    check({tag, "_we_after"}, 16'(mem_we), 16'd0);
    check({tag, "_err"}, 16'(err), 16'd0);
    check({tag, "_byte_cnt"}, 16'(byte_cnt), 16'(cnt));
    check({tag, "_queue_drained"}, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic send_checksum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    send_byte(b);
`else
    if (b != b) send_byte(b);
`endif
  endtask

  initial begin
    // Basic load
    do_reset();
    check_reset_state();
    send_byte(8'h02);
    for (int i = 1; i <= 8; i++) send_data(8'(i * 8'h11));
`ifdef LOADER_CHECKSUM_EN
    send_checksum(xor_m);
`endif
    check_release("basic", 9'd8);
    idle(3);
    check("basic_stays_run", 16'(done), 16'd1);

    // Reset out of RUN clears registered outputs
    do_reset();
    check_reset_state();

    // Illegal length 0
    send_byte(8'h00);
    check("len0_err", 16'(err), 16'd1);
    check("len0_in_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    check("len0_coreR", 16'(core_R), 16'd1);
    check("len0_done", 16'(done), 16'd0);
    check("len0_byte_cnt", 16'(byte_cnt), 16'd0);

    // Illegal length 65
    do_reset();
    send_byte(8'h41);
    check("len65_err", 16'(err), 16'd1);
    check("len65_in_ready", 16'(in_ready), 16'd0);
    idle(2);
    check("len65_coreR", 16'(core_R), 16'd1);

    // Stalls between bytes
    do_reset();
    send_byte(8'h01);
    idle(3);
    send_data(8'hDE); idle(3);
    send_data(8'hAD); idle(3);
    send_data(8'hBE); idle(3);
    check("stall_not_done", 16'(done), 16'd0);
    check("stall_cnt_mid", 16'(byte_cnt), 16'd3);
`ifdef LOADER_CHECKSUM_EN
    send_data(8'hEF); idle(3);
    send_checksum(xor_m);
`else
    send_data(8'hEF);
`endif
    check_release("stall", 9'd4);

    // Mid-load reset, then a fresh image
    do_reset();
    send_byte(8'h04);
    for (int i = 0; i < 5; i++) send_data(8'(8'hC0 + i));
    check("midload_cnt", 16'(byte_cnt), 16'd5);
    do_reset();
    check("midload_rst_cnt", 16'(byte_cnt), 16'd0);
    check("midload_rst_coreR", 16'(core_R), 16'd1);
    send_byte(8'h01);
    send_data(8'hAA); send_data(8'hBB); send_data(8'hCC); send_data(8'hDD);
`ifdef LOADER_CHECKSUM_EN
    send_checksum(xor_m);
`endif
    check_release("midload", 9'd4);

    // Full 64-word image
    do_reset();
    send_byte(8'h40);
    for (int i = 0; i < 256; i++) send_data(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send_checksum(xor_m);
`endif
    check_release("full", 9'd256);
    check("full_last_addr", 16'(mem_addr), 16'h00FF);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    do_reset();
    send_byte(8'h01);
    send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
    send_checksum(8'h0F);
    check_release("cksum_ok", 9'd4);

    do_reset();
    send_byte(8'h01);
    send_data(8'h01); send_data(8'h02); send_data(8'h04); send_data(8'h08);
    send_checksum(8'h0E);
    idle(2);
    check("cksum_bad_err", 16'(err), 16'd1);
    check("cksum_bad_coreR", 16'(core_R), 16'd1);
    check("cksum_bad_done", 16'(done), 16'd0);
    check("cksum_bad_in_ready", 16'(in_ready), 16'd0);
`endif

    idle(2);
    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader upstream of the pipelined core. It receives a byte stream over a valid/ready handshake and writes it byte-by-byte into instruction ROM and data RAM through a shared byte write port. It holds the core pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB, PSR) in reset until the image is complete. It replaces file-based memory preload, so the same program image can be delivered in simulation and in hardware.

## Interface
Parameters
- ADDR_W, 8, byte address width of ROM/RAM; must be 8.
- MAX_WORDS, 64, largest legal image in 32-bit words (4*MAX_WORDS <= 2^ADDR_W).

Ports
- clk  in  1  system clock; all state changes on rising edge.
- R  in  1  reset, synchronous, active-high.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  write strobe, shared by ROM and RAM.
- mem_addr  out  8  byte address for write.
- mem_data  out  8  byte to write.
- core_R  out  1  reset to the pipeline; 1 = hold core in reset.
- done  out  1  image loaded; core running.
- err  out  1  load failed; core held in reset.
- byte_cnt  out  9  bytes written so far (0..256).

## Operation
- Accept: a byte is accepted on a rising edge where in_valid && in_ready. in_data is ignored when in_ready = 0.
- States:
  - LEN: in_ready = 1. The accepted byte L is the image length in words.
    - 1 <= L <= MAX_WORDS: go to DATA; latch total = 4*L.
    - Otherwise (L = 0 or L > MAX_WORDS): go to ERR.
  - DATA: in_ready = 1. Each accepted byte is written to address byte_cnt, then byte_cnt increments.
    - On the byte where byte_cnt reaches total: go to CHK if configured, else RUN.
  - CHK (configured only): in_ready = 1. Accepts one checksum byte.
    - Match: go to RUN.
    - Mismatch: go to ERR.
  - RUN: in_ready = 0, done = 1, core_R = 0. Terminal until R.
  - ERR: in_ready = 0, err = 1, core_R = 1. Terminal until R.
- Byte order: the image is byte-addressed exactly as the ROM is indexed by PC[7:0]. The first data byte goes to address 0. Multi-byte order is defined by the stream source; the loader does not reorder.
- Arithmetic: byte_cnt is 9 bits and never wraps. mem_addr = byte_cnt[7:0] at the time of acceptance. total <= 256 by construction.
- core_R is a registered version of (state != RUN), so every write lands before the core leaves reset.

## Timing
- Reset values (cycle after the R edge): state = LEN, in_ready = 1, mem_we = 0, mem_addr = 0, mem_data = 0, core_R = 1, done = 0, err = 0, byte_cnt = 0.
- Write latency: a byte accepted at edge k gives mem_we = 1 with mem_addr/mem_data valid during the cycle after edge k. mem_we is otherwise 0 and lasts exactly one cycle per byte.
- Back-to-back: one byte per cycle is sustained; in_ready stays 1 through LEN/DATA/CHK with no bubbles. Gaps in in_valid stall the loader with no side effects.
- Release: last data byte (or checksum byte) accepted at edge k. State becomes RUN at k, the last mem_we is high in cycle k..k+1, done rises at k, and core_R falls at edge k+1.
- R asserted at any edge, including mid-DATA or in RUN, overrides everything. The loader returns to LEN with core_R = 1 from the next cycle.
  - Memory contents already written are not cleared.
  - A byte presented on the same edge as R is dropped.
- R held high: the loader stays in LEN with outputs at reset values, and in_ready = 1 is ignored.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHK state exists. The stream is L, 4L data bytes, then one checksum byte equal to the XOR of all 4L data bytes; the length byte is excluded.
  - The running XOR register resets to 0 in LEN.
  - Mismatch → ERR, err = 1, core stays in reset.
- Undefined: no CHK state, no XOR register. DATA goes straight to RUN after the last byte, and err is asserted only for an illegal length.

## Test plan
- Basic load: R for 1 cycle, then stream 02, 11, 22, 33, 44, 55, 66, 77, 88 back-to-back (plus checksum 88 if enabled).
  - Response: 8 mem_we pulses at addresses 0..7 with data 11..88; byte_cnt = 8; done = 1; core_R falls one cycle after the final accept.
- Illegal length: stream 00, and separately 41 (65 words).
  - Response: err = 1, in_ready = 0, core_R stays 1, no mem_we pulse.
- Stalls: L = 01, bytes DE, AD, BE, EF with in_valid low 3 cycles between each.
  - Response: exactly 4 writes at addresses 0..3, no duplicates; done only after the last byte.
- Mid-load reset: L = 04, 5 data bytes accepted, R for 1 cycle, then a full L = 01 image AA, BB, CC, DD.
  - Response: the new writes start at address 0; byte_cnt ends at 4; done = 1.
- Full image: L = 40 (64 words), 256 bytes with value = address.
  - Response: the last write goes to address FF; byte_cnt = 256; no wrap writes to 0.
- Checksum (LOADER_CHECKSUM_EN only): L = 01, bytes 01, 02, 04, 08.
  - Checksum 0F → done = 1.
  - Checksum 0E → err = 1, core_R = 1, done = 0.
